// File: rtl/solo_squash_game_if.sv
// Pad-side signal bundle for the squash game: active-low player controls in, VGA colour/sync and
// speaker out.
interface solo_squash_game_if;
    logic pause_n;
    logic new_game_n;
    logic up_key_n;
    logic down_key_n;
    logic red;
    logic green;
    logic blue;
    logic hsync;
    logic vsync;
    logic speaker;

    modport slave (
        input  pause_n, new_game_n, up_key_n, down_key_n,
        output red, green, blue, hsync, vsync, speaker
    );

    modport master (
        output pause_n, new_game_n, up_key_n, down_key_n,
        input  red, green, blue, hsync, vsync, speaker
    );
endinterface

// File: rtl/solo_squash_game.sv
// Single-player VGA squash: raster timing, once-per-frame ball/paddle update, 1-bit RGB render
// and a bounce/miss tone. Game geometry is in 640x480 screen pixels regardless of raster timing.
module solo_squash_game #(
    parameter int unsigned HVis  = 640,
    parameter int unsigned HFp   = 16,
    parameter int unsigned HSync = 96,
    parameter int unsigned HBp   = 48,
    parameter int unsigned VVis  = 480,
    parameter int unsigned VFp   = 10,
    parameter int unsigned VSync = 2,
    parameter int unsigned VBp   = 33
) (
    input  logic              clk,
    input  logic              resetb,
    solo_squash_game_if.slave bus
);
    localparam logic [9:0] HLast      = 10'(HVis + HFp + HSync + HBp - 1);
    localparam logic [9:0] VLast      = 10'(VVis + VFp + VSync + VBp - 1);
    localparam logic [9:0] HSyncStart = 10'(HVis + HFp);
    localparam logic [9:0] HSyncEnd   = 10'(HVis + HFp + HSync);
    localparam logic [9:0] VSyncStart = 10'(VVis + VFp);
    localparam logic [9:0] VSyncEnd   = 10'(VVis + VFp + VSync);
    localparam logic [9:0] HVisEnd    = 10'(HVis);
    localparam logic [9:0] VVisEnd    = 10'(VVis);

    localparam logic [9:0] Wall       = 10'd16;
    localparam logic [9:0] Ball       = 10'd16;
    localparam logic [9:0] PadH       = 10'd64;
    localparam logic [9:0] PadX       = 10'd608;
    localparam logic [9:0] PadW       = 10'd8;
    localparam logic [9:0] PadStep    = 10'd4;
    localparam logic [9:0] ScreenW    = 10'd640;
    localparam logic [9:0] FloorY     = 10'd464;
    localparam logic [9:0] PyMin      = 10'd16;
    localparam logic [9:0] PyMax      = 10'd400;
    localparam logic [9:0] BxInit     = 10'd320;
    localparam logic [9:0] ByInit     = 10'd240;
    localparam logic [9:0] PyInit     = 10'd208;
    localparam logic [4:0] HitFrames  = 5'd8;
    localparam logic [4:0] MissFrames = 5'd16;

    logic [9:0] h_q, v_q;
    logic [3:0] meta_q, sync_q;
    logic [9:0] bx_q, bx_d, by_q, by_d, py_q, py_d;
    logic       dx_q, dx_d, dy_q, dy_d;
    logic [4:0] hit_tmr_q, hit_tmr_d, miss_tmr_q, miss_tmr_d;
    logic [2:0] rgb_q, rgb_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d, speaker_q, speaker_d;

    logic       tick, pause, new_game, up, down;
    logic [9:0] nbx, nby;
    logic       ndx, ndy, bounce, miss;
    logic       visible, ball_px, pad_px, wall_px;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == HLast) begin
            h_q <= '0;
            v_q <= (v_q == VLast) ? '0 : v_q + 10'd1;
        end else begin
            h_q <= h_q + 10'd1;
        end
    end

    // Sync flops reset to all-ones so every control starts inactive.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= {bus.pause_n, bus.new_game_n, bus.up_key_n, bus.down_key_n};
            sync_q <= meta_q;
        end
    end

    assign pause    = !sync_q[3];
    assign new_game = !sync_q[2];
    assign up       = !sync_q[1];
    assign down     = !sync_q[0];
    assign tick     = (h_q == 10'd0) && (v_q == VVisEnd);

    always_comb begin
        bx_d       = bx_q;
        by_d       = by_q;
        py_d       = py_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        hit_tmr_d  = hit_tmr_q;
        miss_tmr_d = miss_tmr_q;
        nbx        = dx_q ? bx_q + 10'd1 : bx_q - 10'd1;
        nby        = dy_q ? by_q + 10'd1 : by_q - 10'd1;
        ndx        = dx_q;
        ndy        = dy_q;
        bounce     = 1'b0;
        miss       = 1'b0;
        if (tick) begin
            if (hit_tmr_q != 5'd0)  hit_tmr_d  = hit_tmr_q - 5'd1;
            if (miss_tmr_q != 5'd0) miss_tmr_d = miss_tmr_q - 5'd1;
            if (new_game) begin
                bx_d = BxInit;
                by_d = ByInit;
                py_d = PyInit;
                dx_d = 1'b1;
                dy_d = 1'b1;
            end else if (!pause) begin
                if (up && !down) begin
                    py_d = (py_q <= PyMin + PadStep) ? PyMin : py_q - PadStep;
                end else if (down && !up) begin
                    py_d = (py_q >= PyMax - PadStep) ? PyMax : py_q + PadStep;
                end
                if (nbx <= Wall) begin
                    ndx    = 1'b1;
                    bounce = 1'b1;
                end
                if (nby <= Wall) begin
                    ndy    = 1'b1;
                    bounce = 1'b1;
                end
                if (nby + Ball >= FloorY) begin
                    ndy    = 1'b0;
                    bounce = 1'b1;
                end
                // Paddle hit tests the paddle as it stood before this frame's move.
                if (dx_q && (nbx + Ball >= PadX) && (nby + Ball > py_q) && (nby < py_q + PadH)) begin
                    ndx    = 1'b0;
                    bounce = 1'b1;
                end
                if (nbx + Ball >= ScreenW) begin
                    nbx  = BxInit;
                    nby  = ByInit;
                    ndx  = 1'b0;
                    miss = 1'b1;
                end
                bx_d = nbx;
                by_d = nby;
                dx_d = ndx;
                dy_d = ndy;
                if (bounce) hit_tmr_d  = HitFrames;
                if (miss)   miss_tmr_d = MissFrames;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            bx_q       <= BxInit;
            by_q       <= ByInit;
            py_q       <= PyInit;
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            hit_tmr_q  <= '0;
            miss_tmr_q <= '0;
        end else begin
            bx_q       <= bx_d;
            by_q       <= by_d;
            py_q       <= py_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            hit_tmr_q  <= hit_tmr_d;
            miss_tmr_q <= miss_tmr_d;
        end
    end

    always_comb begin
        visible = (h_q < HVisEnd) && (v_q < VVisEnd);
        ball_px = (h_q >= bx_q) && (h_q < bx_q + Ball) && (v_q >= by_q) && (v_q < by_q + Ball);
        pad_px  = (h_q >= PadX) && (h_q < PadX + PadW) && (v_q >= py_q) && (v_q < py_q + PadH);
        wall_px = (v_q < Wall) || (v_q >= FloorY) || (h_q < Wall);
        rgb_d   = 3'b000;
        if (visible) begin
            if (ball_px)      rgb_d = 3'b110;
            else if (pad_px)  rgb_d = 3'b111;
            else if (wall_px) rgb_d = 3'b010;
        end
        hsync_d   = !((h_q >= HSyncStart) && (h_q < HSyncEnd));
        vsync_d   = !((v_q >= VSyncStart) && (v_q < VSyncEnd));
        speaker_d = (miss_tmr_q != 5'd0) ? v_q[6] : (hit_tmr_q != 5'd0) ? v_q[4] : 1'b0;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rgb_q     <= 3'b000;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            speaker_q <= 1'b0;
        end else begin
            rgb_q     <= rgb_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            speaker_q <= speaker_d;
        end
    end

    assign bus.red     = rgb_q[2];
    assign bus.green   = rgb_q[1];
    assign bus.blue    = rgb_q[0];
    assign bus.hsync   = hsync_q;
    assign bus.vsync   = vsync_q;
    assign bus.speaker = speaker_q;
endmodule

// File: tb/tb_solo_squash_game.sv
// Bench for solo_squash_game: a full-timing instance checks line timing and rendering near the
// top of the frame; a short-raster instance plays hundreds of frames of game logic quickly.
module tb_solo_squash_game;
    // Short raster: 2 clocks per line, 66 lines per frame; vsync falls at line 62.
    localparam int SmallFrame = 132;

    logic clk = 1'b0;
    logic rst_full_n = 1'b0;
    logic rst_small_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    int cur_m = 0;
    logic [29:0] st;

    always #5 clk = ~clk;

    solo_squash_game_if bus_full ();
    solo_squash_game_if bus_small ();

    solo_squash_game u_full (
        .clk(clk),
        .resetb(rst_full_n),
        .bus(bus_full)
    );

    solo_squash_game #(
        .HVis(1), .HFp(0), .HSync(1), .HBp(0),
        .VVis(60), .VFp(2), .VSync(2), .VBp(2)
    ) u_small (
        .clk(clk),
        .resetb(rst_small_n),
        .bus(bus_small)
    );

    // Waits for n vsync falls of the short instance; each fall follows exactly one game tick.
    task automatic wait_frames(input int n);
        logic prev;
        bit seen;
        int budget;
        for (int i = 0; i < n; i++) begin
            prev = bus_small.vsync;
            seen = 1'b0;
            budget = 0;
            while (!seen) begin
                @(negedge clk);
                budget++;
                if (prev && !bus_small.vsync) seen = 1'b1;
                prev = bus_small.vsync;
                if (!seen && budget > 2 * SmallFrame) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_wait: no vsync fall after %0d clocks, want <= %0d",
                             budget, 2 * SmallFrame);
                    $display("End of test - %0d assertions evaluated, %0d failures",
                             n_checks, n_fail);
                    $finish;
                end
            end
        end
        cur_m = 0;
    endtask

    // Outputs seen m lines after a vsync fall reflect raster line (62 + m) mod 66.
    task automatic goto_line(input int m);
        repeat (2 * (m - cur_m)) @(negedge clk);
        cur_m = m;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus_full.red, bus_full.green, bus_full.blue, bus_full.hsync, bus_full.vsync,
             bus_full.speaker} !== 6'b000110) begin
            n_fail++;
            $display("FAIL reset_full_outputs: got %b, want 000110", {bus_full.red,
                     bus_full.green, bus_full.blue, bus_full.hsync, bus_full.vsync,
                     bus_full.speaker});
        end
        n_checks++;
        if ({bus_small.red, bus_small.green, bus_small.blue, bus_small.hsync, bus_small.vsync,
             bus_small.speaker} !== 6'b000110) begin
            n_fail++;
            $display("FAIL reset_small_outputs: got %b, want 000110", {bus_small.red,
                     bus_small.green, bus_small.blue, bus_small.hsync, bus_small.vsync,
                     bus_small.speaker});
        end
        n_checks++;
        if ({u_full.h_q, u_full.v_q} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got h=%0d v=%0d, want 0 0", u_full.h_q, u_full.v_q);
        end
        st = {u_small.bx_q, u_small.by_q, u_small.py_q};
        n_checks++;
        if (st !== {10'd320, 10'd240, 10'd208}) begin
            n_fail++;
            $display("FAIL reset_state: got bx=%0d by=%0d py=%0d, want 320 240 208",
                     st[29:20], st[19:10], st[9:0]);
        end
    endtask

    task automatic test_full_timing();
        int rgb_idx [7] = '{0, 639, 640, 15 * 800 + 300, 16 * 800 + 15, 16 * 800 + 16,
                            16 * 800 + 608};
        logic [2:0] rgb_exp [7] = '{3'b010, 3'b010, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000};
        int hs_idx [5] = '{655, 656, 751, 752, 17 * 800 + 700};
        logic hs_exp [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int hs_low = 0;
        int vs_low = 0;
        @(negedge clk);
        rst_full_n = 1'b1;
        for (int c = 0; c <= 17 * 800 + 700; c++) begin
            @(negedge clk);
            if (c < 800 && !bus_full.hsync) hs_low++;
            if (!bus_full.vsync) vs_low++;
            for (int p = 0; p < 7; p++) begin
                if (c == rgb_idx[p]) begin
                    n_checks++;
                    if ({bus_full.red, bus_full.green, bus_full.blue} !== rgb_exp[p]) begin
                        n_fail++;
                        $display("FAIL pixel_rgb v=%0d h=%0d: got %b, want %b", c / 800, c % 800,
                                 {bus_full.red, bus_full.green, bus_full.blue}, rgb_exp[p]);
                    end
                end
            end
            for (int p = 0; p < 5; p++) begin
                if (c == hs_idx[p]) begin
                    n_checks++;
                    if (bus_full.hsync !== hs_exp[p]) begin
                        n_fail++;
                        $display("FAIL hsync v=%0d h=%0d: got %b, want %b", c / 800, c % 800,
                                 bus_full.hsync, hs_exp[p]);
                    end
                end
            end
        end
        n_checks++;
        if (hs_low != 96) begin
            n_fail++;
            $display("FAIL hsync_width: got %0d low clocks per line, want 96", hs_low);
        end
        n_checks++;
        if (vs_low != 0) begin
            n_fail++;
            $display("FAIL vsync_top_lines: got %0d low clocks in lines 0..17, want 0", vs_low);
        end
        // Mid-line asynchronous reset while hsync is low.
        #1 rst_full_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_full.red, bus_full.green, bus_full.blue, bus_full.hsync, bus_full.vsync,
             bus_full.speaker} !== 6'b000110) begin
            n_fail++;
            $display("FAIL midline_reset_outputs: got %b, want 000110", {bus_full.red,
                     bus_full.green, bus_full.blue, bus_full.hsync, bus_full.vsync,
                     bus_full.speaker});
        end
        n_checks++;
        if ({u_full.h_q, u_full.v_q} !== 20'd0) begin
            n_fail++;
            $display("FAIL midline_reset_counters: got h=%0d v=%0d, want 0 0",
                     u_full.h_q, u_full.v_q);
        end
    endtask

    task automatic test_first_tick();
        @(negedge clk);
        rst_small_n = 1'b1;
        wait_frames(1);
        st = {u_small.bx_q, u_small.by_q, u_small.py_q};
        n_checks++;
        if (st !== {10'd321, 10'd241, 10'd208}) begin
            n_fail++;
            $display("FAIL first_tick: got bx=%0d by=%0d py=%0d, want 321 241 208",
                     st[29:20], st[19:10], st[9:0]);
        end
    endtask

    task automatic test_sync_small();
        int hs = 0;
        int vs = 0;
        for (int i = 0; i < SmallFrame; i++) begin
            @(negedge clk);
            if (!bus_small.hsync) hs++;
            if (!bus_small.vsync) vs++;
        end
        cur_m = 0;
        n_checks++;
        if (hs != 66) begin
            n_fail++;
            $display("FAIL frame_hsync_count: got %0d, want 66", hs);
        end
        n_checks++;
        if (vs != 4) begin
            n_fail++;
            $display("FAIL frame_vsync_count: got %0d, want 4", vs);
        end
        st = {u_small.bx_q, u_small.by_q, u_small.py_q};
        n_checks++;
        if (st !== {10'd322, 10'd242, 10'd208}) begin
            n_fail++;
            $display("FAIL second_tick: got bx=%0d by=%0d py=%0d, want 322 242 208",
                     st[29:20], st[19:10], st[9:0]);
        end
    endtask

    task automatic test_paddle();
        bus_small.up_key_n = 1'b0;
        wait_frames(60);
        bus_small.up_key_n = 1'b1;
        st = {u_small.bx_q, u_small.by_q, u_small.py_q};
        n_checks++;
        if (st !== {10'd382, 10'd302, 10'd16}) begin
            n_fail++;
            $display("FAIL paddle_top_clamp: got bx=%0d by=%0d py=%0d, want 382 302 16",
                     st[29:20], st[19:10], st[9:0]);
        end
        bus_small.down_key_n = 1'b0;
        wait_frames(100);
        bus_small.down_key_n = 1'b1;
        st = {u_small.bx_q, u_small.by_q, u_small.py_q};
        n_checks++;
        if (st !== {10'd482, 10'd402, 10'd400}) begin
            n_fail++;
            $display("FAIL paddle_bottom_clamp: got bx=%0d by=%0d py=%0d, want 482 402 400",
                     st[29:20], st[19:10], st[9:0]);
        end
    endtask

    task automatic test_floor_bounce();
        wait_frames(46);
        st = {u_small.bx_q, u_small.by_q, u_small.py_q};
        n_checks++;
        if (st !== {10'd528, 10'd448, 10'd400}) begin
            n_fail++;
            $display("FAIL floor_reach: got bx=%0d by=%0d py=%0d, want 528 448 400",
                     st[29:20], st[19:10], st[9:0]);
        end
        goto_line(4);
        n_checks++;
        if (bus_small.speaker !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_tone_v0: got %b, want 0", bus_small.speaker);
        end
        goto_line(20);
        n_checks++;
        if (bus_small.speaker !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_tone_v16: got %b, want 1", bus_small.speaker);
        end
        wait_frames(1);
        st = {u_small.bx_q, u_small.by_q, u_small.py_q};
        n_checks++;
        if (st !== {10'd529, 10'd447, 10'd400}) begin
            n_fail++;
            $display("FAIL floor_rebound: got bx=%0d by=%0d py=%0d, want 529 447 400",
                     st[29:20], st[19:10], st[9:0]);
        end
        wait_frames(6);
        goto_line(20);
        n_checks++;
        if (bus_small.speaker !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_tone_frame8: got %b, want 1", bus_small.speaker);
        end
        wait_frames(1);
        goto_line(20);
        n_checks++;
        if (bus_small.speaker !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_tone_expired: got %b, want 0", bus_small.speaker);
        end
    endtask

    task automatic test_miss();
        wait_frames(88);
        st = {u_small.bx_q, u_small.by_q, u_small.py_q};
        n_checks++;
        if (st !== {10'd320, 10'd240, 10'd400}) begin
            n_fail++;
            $display("FAIL miss_recentre: got bx=%0d by=%0d py=%0d, want 320 240 400",
                     st[29:20], st[19:10], st[9:0]);
        end
        goto_line(2);
        n_checks++;
        if (bus_small.speaker !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_tone_v64: got %b, want 1", bus_small.speaker);
        end
        goto_line(4);
        n_checks++;
        if (bus_small.speaker !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_tone_v0: got %b, want 0", bus_small.speaker);
        end
        goto_line(20);
        n_checks++;
        if (bus_small.speaker !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_tone_v16: got %b, want 0", bus_small.speaker);
        end
        wait_frames(1);
        st = {u_small.bx_q, u_small.by_q, u_small.py_q};
        n_checks++;
        if (st !== {10'd319, 10'd239, 10'd400}) begin
            n_fail++;
            $display("FAIL miss_direction: got bx=%0d by=%0d py=%0d, want 319 239 400",
                     st[29:20], st[19:10], st[9:0]);
        end
        wait_frames(14);
        goto_line(2);
        n_checks++;
        if (bus_small.speaker !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_tone_frame16: got %b, want 1", bus_small.speaker);
        end
        wait_frames(1);
        goto_line(2);
        n_checks++;
        if (bus_small.speaker !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_tone_expired: got %b, want 0", bus_small.speaker);
        end
    endtask

    task automatic test_pause_new_game();
        bus_small.pause_n = 1'b0;
        bus_small.up_key_n = 1'b0;
        wait_frames(10);
        bus_small.pause_n = 1'b1;
        bus_small.up_key_n = 1'b1;
        st = {u_small.bx_q, u_small.by_q, u_small.py_q};
        n_checks++;
        if (st !== {10'd304, 10'd224, 10'd400}) begin
            n_fail++;
            $display("FAIL pause_hold: got bx=%0d by=%0d py=%0d, want 304 224 400",
                     st[29:20], st[19:10], st[9:0]);
        end
        wait_frames(1);
        st = {u_small.bx_q, u_small.by_q, u_small.py_q};
        n_checks++;
        if (st !== {10'd303, 10'd223, 10'd400}) begin
            n_fail++;
            $display("FAIL pause_resume: got bx=%0d by=%0d py=%0d, want 303 223 400",
                     st[29:20], st[19:10], st[9:0]);
        end
        bus_small.new_game_n = 1'b0;
        bus_small.pause_n = 1'b0;
        wait_frames(1);
        bus_small.new_game_n = 1'b1;
        bus_small.pause_n = 1'b1;
        st = {u_small.bx_q, u_small.by_q, u_small.py_q};
        n_checks++;
        if (st !== {10'd320, 10'd240, 10'd208}) begin
            n_fail++;
            $display("FAIL new_game_reload: got bx=%0d by=%0d py=%0d, want 320 240 208",
                     st[29:20], st[19:10], st[9:0]);
        end
        wait_frames(1);
        st = {u_small.bx_q, u_small.by_q, u_small.py_q};
        n_checks++;
        if (st !== {10'd321, 10'd241, 10'd208}) begin
            n_fail++;
            $display("FAIL new_game_direction: got bx=%0d by=%0d py=%0d, want 321 241 208",
                     st[29:20], st[19:10], st[9:0]);
        end
    endtask

    task automatic test_both_keys();
        bus_small.up_key_n = 1'b0;
        bus_small.down_key_n = 1'b0;
        wait_frames(1);
        bus_small.up_key_n = 1'b1;
        bus_small.down_key_n = 1'b1;
        st = {u_small.bx_q, u_small.by_q, u_small.py_q};
        n_checks++;
        if (st !== {10'd322, 10'd242, 10'd208}) begin
            n_fail++;
            $display("FAIL both_keys_hold: got bx=%0d by=%0d py=%0d, want 322 242 208",
                     st[29:20], st[19:10], st[9:0]);
        end
    endtask

    initial begin
        bus_full.pause_n = 1'b1;
        bus_full.new_game_n = 1'b1;
        bus_full.up_key_n = 1'b1;
        bus_full.down_key_n = 1'b1;
        bus_small.pause_n = 1'b1;
        bus_small.new_game_n = 1'b1;
        bus_small.up_key_n = 1'b1;
        bus_small.down_key_n = 1'b1;
        test_reset();
        test_full_timing();
        test_first_tick();
        test_sync_small();
        test_paddle();
        test_floor_bounce();
        test_miss();
        test_pause_new_game();
        test_both_keys();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
